dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate data cache sitting directly downstream of the pipeline's memory stage, between the execute/memory pipeline register outputs and the external data memory. It serves loads from on-chip line storage, refills missing lines word-by-word over a req/ack memory port, and forwards every store to memory. While a request is outstanding it raises a stall consumed by the hazard unit, which freezes F/D/E/M.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- SETS, 64, number of lines; power of two.
- WORDS_PER_LINE, 4, words per line; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemReadM  in  1  load present in M stage.
- MemWriteM  in  1  store present in M stage.
- AddrModeM  in  1  0 = word access, 1 = byte access.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load result.
- StallM  out  1  request not complete; pipeline must hold all M inputs stable.
- mem_req, mem_we  out  1  memory request / write enable.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32; mem_wstrb  out  4  write data and byte strobes.
- mem_rdata  in  32; mem_ack  in  1  read data / completion, one cycle per request.

## Operation
- Address split: [1:0] byte, next log2(WORDS_PER_LINE) word offset, next log2(SETS) index, remainder tag.
- States: IDLE, REFILL, WRITE, DONE.
- IDLE, write (priority if both MemReadM and MemWriteM high): StallM=1 combinationally; next state WRITE.
- IDLE, read hit (valid && tag match): ReadDataM valid same cycle, StallM=0, stay IDLE.
- IDLE, read miss: StallM=1; clear word counter; next REFILL.
- IDLE, neither: StallM=0, no memory activity.
- REFILL: mem_req=1, mem_we=0, mem_addr = line base + counter*4; held until mem_ack. On ack: store mem_rdata at counter; counter wraps modulo WORDS_PER_LINE; on last ack set tag and valid, go DONE. StallM=1.
- WRITE: mem_req=1, mem_we=1 until ack. Word: wstrb=4'b1111, wdata=WriteDataM, addr[1:0] ignored. Byte: wstrb one-hot at addr[1:0], byte replicated on all lanes. On ack: if line hit, merge strobed bytes into cached word; go DONE. StallM=1.
- DONE: StallM=0, inputs ignored, ReadDataM from array (load now hits); next IDLE. Prevents reissuing the held request.
- Byte load: ReadDataM = zero-extended selected byte; word load: full word.
- mem_ack outside REFILL/WRITE ignored. mem_req never drops before ack.
- Reset (including mid-refill/write): all valid bits 0, state IDLE, counter 0, mem_req 0; partially refilled line stays invalid.

## Timing
- Load hit: 0 added cycles.
- Load miss with memory ack latency L (cycles req→ack, L≥1): StallM high for WORDS_PER_LINE*L cycles +1 (IDLE detection cycle), low in DONE.
- Store: StallM high for L+1 cycles, low in DONE.
- Outputs at reset: StallM=0 (inputs idle), mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, ReadDataM=0.
- Back-to-back requests: each costs one DONE cycle; no overlap of memory transactions.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count and miss_count (32 bits each, reset 0); incremented on IDLE read hit / IDLE read miss respectively; saturate at 32'hFFFFFFFF; stores not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package dcache_pkg: state enum, DATA_WIDTH-derived localparams, helper functions for index/tag/offset widths, byte-strobe encode.
- One sub-module dcache_array: valid (async reset), tag and data storage with combinational read and byte-enabled synchronous write; top holds FSM, counter, memory port.

## Test plan
- Reset, then load word 0x100 with memory L=2 holding 0xDEADBEEF → StallM high 9 cycles, 4 reqs at 0x100/104/108/10C, ReadDataM=0xDEADBEEF in DONE.
- Second load of 0x104 → StallM=0, hit same cycle, no mem_req.
- Byte store 0xA5 to 0x102 on cached line → mem_wstrb=4'b0100, mem_wdata=0xA5A5A5A5; subsequent word load 0x100 returns 0xDEA5BEEF.
- Load 0x100+SETS*16 (same index, new tag) → refill evicts; reload of 0x100 misses again.
- Assert rst during third refill ack → mem_req=0 immediately, load of 0x100 afterwards misses.
- With DCACHE_STATS_EN: sequence above yields hit_count and miss_count matching scoreboard counts.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DW     = 32;
    localparam int BYTES  = DW / 8;
    localparam int BOFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE,
        S_DONE
    } state_e;

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int off_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int tag_width(input int sets, input int words_per_line);
        return DW - BOFF_W - idx_width(sets) - off_width(words_per_line);
    endfunction

    // Byte access enables one lane; word access enables all of them.
    function automatic logic [BYTES-1:0] byte_strb(input logic byte_mode,
                                                   input logic [BOFF_W-1:0] boff);
        logic [BYTES-1:0] s;
        s = byte_mode ? (BYTES'(1) << boff) : '1;
        return s;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid bits (async reset), tags and data words with
// combinational read and byte-enabled synchronous write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W = idx_width(SETS),
    localparam int OFF_W = off_width(WORDS_PER_LINE),
    localparam int TAG_W = tag_width(SETS, WORDS_PER_LINE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [OFF_W-1:0] rd_off_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [DW-1:0]    rd_data_o,
    input  logic             inval_i,
    input  logic             tag_we_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             data_we_i,
    input  logic [OFF_W-1:0] wr_off_i,
    input  logic [BYTES-1:0] wr_be_i,
    input  logic [DW-1:0]    wr_data_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [DW-1:0]    data_q [SETS*WORDS_PER_LINE];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (inval_i) begin
            valid_q[idx_i] <= 1'b0;
        end else if (tag_we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_q[idx_i] <= tag_i;
        end
        if (data_we_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be_i[b]) begin
                    data_q[{idx_i, wr_off_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[{idx_i, rd_off_i}];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic                  AddrModeM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [BYTES-1:0]      mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int IDX_W = idx_width(SETS);
    localparam int OFF_W = off_width(WORDS_PER_LINE);
    localparam int TAG_W = tag_width(SETS, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [OFF_W-1:0]  a_off;
    logic [BOFF_W-1:0] a_boff;

    assign a_tag  = ALUResultM[DATA_WIDTH-1 -: TAG_W];
    assign a_idx  = ALUResultM[BOFF_W+OFF_W +: IDX_W];
    assign a_off  = ALUResultM[BOFF_W +: OFF_W];
    assign a_boff = ALUResultM[BOFF_W-1:0];

    state_e           state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic             arr_valid;
    logic [TAG_W-1:0] arr_tag;
    logic [DW-1:0]    arr_word;
    logic             hit;
    logic             inval, tag_we, data_we, rd_en;
    logic [OFF_W-1:0] wr_off;
    logic [BYTES-1:0] wr_be;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    store_data;
    logic [BYTES-1:0] store_strb;

    dcache_array #(
        .SETS          (SETS),
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_array (
        .clk_i     (clk),
        .rst_i     (rst),
        .idx_i     (a_idx),
        .rd_off_i  (a_off),
        .rd_valid_o(arr_valid),
        .rd_tag_o  (arr_tag),
        .rd_data_o (arr_word),
        .inval_i   (inval),
        .tag_we_i  (tag_we),
        .tag_i     (a_tag),
        .data_we_i (data_we),
        .wr_off_i  (wr_off),
        .wr_be_i   (wr_be),
        .wr_data_i (wr_data)
    );

    assign hit        = arr_valid && (arr_tag == a_tag);
    assign store_strb = byte_strb(AddrModeM, a_boff);
    assign store_data = AddrModeM ? {BYTES{WriteDataM[7:0]}} : WriteDataM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        StallM    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        inval     = 1'b0;
        tag_we    = 1'b0;
        data_we   = 1'b0;
        rd_en     = 1'b0;
        wr_off    = a_off;
        wr_be     = '0;
        wr_data   = mem_rdata;
        case (state_q)
            S_IDLE: begin
                if (MemWriteM) begin
                    StallM  = 1'b1;
                    state_d = S_WRITE;
                end else if (MemReadM) begin
                    if (hit) begin
                        rd_en = 1'b1;
                    end else begin
                        // Invalidate up front so a refill cut short by reset never looks valid.
                        StallM  = 1'b1;
                        inval   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                StallM   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {a_tag, a_idx, cnt_q, {BOFF_W{1'b0}}};
                if (mem_ack) begin
                    data_we = 1'b1;
                    wr_off  = cnt_q;
                    wr_be   = '1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        tag_we  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                StallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {ALUResultM[DATA_WIDTH-1:BOFF_W], {BOFF_W{1'b0}}};
                mem_wdata = store_data;
                mem_wstrb = store_strb;
                if (mem_ack) begin
                    data_we = hit;
                    wr_be   = store_strb;
                    wr_data = store_data;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rd_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ReadDataM = '0;
        if (rd_en && hit) begin
            ReadDataM = AddrModeM ? {{(DATA_WIDTH-8){1'b0}}, arr_word[8*a_boff +: 8]} : arr_word;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        rd_idle;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    assign rd_idle = (state_q == S_IDLE) && MemReadM && !MemWriteM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rd_idle) begin
            if (hit && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (!hit && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: memory model with configurable ack latency.
module tb_dcache;

    logic        clk;
    logic        rst;
    logic        MemReadM, MemWriteM, AddrModeM;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .AddrModeM (AddrModeM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .StallM    (StallM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack arrives in the lat-th cycle of each request.
    logic [31:0] tbmem [0:1023];
    logic        mem_init = 1'b0;
    int          lat;
    int          wcnt = 0;
    int          req_cycles = 0;
    logic [31:0] ack_log [$];
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata;

    assign mem_ack   = mem_req && (wcnt == lat - 1);
    assign mem_rdata = tbmem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) tbmem[i] <= 32'h1000_0000 + i;
            tbmem[32'h40] <= 32'hDEAD_BEEF;
            mem_init <= 1'b1;
        end
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_req && mem_ack) begin
            ack_log.push_back(mem_addr);
            if (mem_we) begin
                last_wstrb <= mem_wstrb;
                last_wdata <= mem_wdata;
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) tbmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request, count stall cycles, capture ReadDataM in the first unstalled cycle.
    task automatic access(input logic rd, input logic wr, input logic bm,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int stall, output logic [31:0] rdat);
        MemReadM   = rd;
        MemWriteM  = wr;
        AddrModeM  = bm;
        ALUResultM = a;
        WriteDataM = wd;
        stall      = 0;
        rdat       = 32'hxxxx_xxxx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!StallM) begin
                rdat = ReadDataM;
                break;
            end
            stall++;
        end
        @(posedge clk);
        #1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    initial begin
        int          st;
        int          base;
        int          r0;
        logic [31:0] rd;

        rst = 1'b1; MemReadM = 0; MemWriteM = 0; AddrModeM = 0;
        ALUResultM = 0; WriteDataM = 0; lat = 2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, StallM}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss, L=2.
        base = ack_log.size();
        access(1, 0, 0, 32'h100, 0, st, rd);
        chk("miss_stall", st, 9);
        chk("miss_data", rd, 32'hDEAD_BEEF);
        chk("miss_nreq", ack_log.size() - base, 4);
        for (int k = 0; k < 4; k++)
            if (ack_log.size() > base + k) chk("miss_addr", ack_log[base+k], 32'h100 + 4 * k);

        // Hit on same line, no memory activity.
        r0 = req_cycles;
        access(1, 0, 0, 32'h104, 0, st, rd);
        chk("hit_stall", st, 0);
        chk("hit_data", rd, 32'h1000_0041);
        chk("hit_noreq", req_cycles - r0, 0);

        // Byte store into cached line.
        base = ack_log.size();
        access(0, 1, 1, 32'h102, 32'h0000_00A5, st, rd);
        chk("bst_stall", st, 3);
        chk("bst_wstrb", {28'd0, last_wstrb}, 32'h4);
        chk("bst_wdata", last_wdata, 32'hA5A5_A5A5);
        if (ack_log.size() > base) chk("bst_addr", ack_log[base], 32'h100);
        access(1, 0, 0, 32'h100, 0, st, rd);
        chk("merge_stall", st, 0);
        chk("merge_data", rd, 32'hDEA5_BEEF);
        access(1, 0, 1, 32'h103, 0, st, rd);
        chk("bld_data", rd, 32'h0000_00DE);

        // Word store with L=1.
        lat = 1;
        access(0, 1, 0, 32'h10B, 32'h1234_5678, st, rd);
        chk("wst_stall", st, 2);
        chk("wst_wstrb", {28'd0, last_wstrb}, 32'hF);
        chk("wst_wdata", last_wdata, 32'h1234_5678);
        access(1, 0, 0, 32'h108, 0, st, rd);
        chk("wst_hit", rd, 32'h1234_5678);
        chk("wst_hit_stall", st, 0);
        lat = 2;

        // Conflict eviction: same index, new tag.
        access(1, 0, 0, 32'h500, 0, st, rd);
        chk("evict_stall", st, 9);
        chk("evict_data", rd, 32'h1000_0140);
        access(1, 0, 0, 32'h100, 0, st, rd);
        chk("reload_stall", st, 9);
        chk("reload_data", rd, 32'hDEA5_BEEF);

        // Store miss does not allocate; later load misses with L=1.
        access(0, 1, 0, 32'h200, 32'hCAFE_F00D, st, rd);
        chk("smiss_stall", st, 3);
        lat = 1;
        access(1, 0, 0, 32'h200, 0, st, rd);
        chk("noalloc_stall", st, 5);
        chk("noalloc_data", rd, 32'hCAFE_F00D);
        lat = 2;

`ifdef DCACHE_STATS_EN
        chk("hits", hit_count, 4);
        chk("misses", miss_count, 4);
`endif

        // Reset during third refill ack.
        access(1, 0, 0, 32'h500, 0, st, rd);
        MemReadM = 1'b1; AddrModeM = 1'b0; ALUResultM = 32'h100;
        base = ack_log.size();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_ack && ack_log.size() == base + 2) break;
        end
        chk("pre_rst_ack", {31'd0, mem_ack}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("rst_no3rd", ack_log.size() - base, 2);
        MemReadM = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1, 0, 0, 32'h100, 0, st, rd);
        chk("post_rst_miss", st, 9);
        chk("post_rst_data", rd, 32'hDEA5_BEEF);
        access(1, 0, 0, 32'h10C, 0, st, rd);
        chk("post_rst_hit", st, 0);
        chk("post_rst_hdata", rd, 32'h1000_0043);

`ifdef DCACHE_STATS_EN
        chk("hits_rst", hit_count, 1);
        chk("misses_rst", miss_count, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
